// File: rtl/regfile_wb_ctrl_if.sv
// Result-producer / regfile write-port bundle for regfile_wb_ctrl.
// master: producers + regfile side; slave: the write-back controller.
interface regfile_wb_ctrl_if;
  logic        ld_valid;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        res1_valid;
  logic [4:0]  res1_waddr;
  logic [31:0] res1_wdata;
  logic        res2_valid;
  logic [4:0]  res2_waddr;
  logic [31:0] res2_wdata;
  logic        in_ready;
  logic        we_i1;
  logic [4:0]  waddr_i1;
  logic [31:0] wdata_i1;
  logic        we_i2;
  logic [4:0]  waddr_i2;
  logic [31:0] wdata_i2;
  logic [4:0]  chk_addr0, chk_addr1, chk_addr2, chk_addr3;
  logic        chk_busy0, chk_busy1, chk_busy2, chk_busy3;
  logic [3:0]  occupancy;

  modport master (
    output ld_valid, ld_waddr, ld_wdata,
    output res1_valid, res1_waddr, res1_wdata,
    output res2_valid, res2_waddr, res2_wdata,
    output chk_addr0, chk_addr1, chk_addr2, chk_addr3,
    input  in_ready, we_i1, waddr_i1, wdata_i1, we_i2, waddr_i2, wdata_i2,
    input  chk_busy0, chk_busy1, chk_busy2, chk_busy3, occupancy
  );

  modport slave (
    input  ld_valid, ld_waddr, ld_wdata,
    input  res1_valid, res1_waddr, res1_wdata,
    input  res2_valid, res2_waddr, res2_wdata,
    input  chk_addr0, chk_addr1, chk_addr2, chk_addr3,
    output in_ready, we_i1, waddr_i1, wdata_i1, we_i2, waddr_i2, wdata_i2,
    output chk_busy0, chk_busy1, chk_busy2, chk_busy3, occupancy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back merge buffer: up to 3 results/cycle in (ld, res1, res2 order),
// 8-entry FIFO, drained 2/cycle into a dual-write-port regfile.
module regfile_wb_ctrl (
  input  logic              clk,
  input  logic              resetn,
  regfile_wb_ctrl_if.slave  bus
);
  logic [4:0]  mem_addr [8];
  logic [31:0] mem_data [8];
  logic [2:0]  head, tail;
  logic [3:0]  count;
  logic        v0, v1, v2;
  logic [2:0]  slot1, slot2;
  logic [1:0]  enq_n, deq_n;
  logic [2:0]  head_p1;
  logic [2:0]  off [8];
  logic [7:0]  entry_vld;
  logic [4:0]  chk_addr [4];
  logic [3:0]  chk_busy;

  // Readiness depends only on registered count; 3 free slots guarantee a full cycle fits.
  assign bus.in_ready = (count <= 4'd5);

  assign v0 = bus.in_ready && bus.ld_valid   && (bus.ld_waddr   != 5'd0);
  assign v1 = bus.in_ready && bus.res1_valid && (bus.res1_waddr != 5'd0);
  assign v2 = bus.in_ready && bus.res2_valid && (bus.res2_waddr != 5'd0);

  // Accepted results pack into consecutive slots from tail with no gaps.
  assign slot1 = tail  + {2'b00, v0};
  assign slot2 = slot1 + {2'b00, v1};
  assign enq_n = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
  assign deq_n = (count >= 4'd2) ? 2'd2 : {1'b0, count[0]};

  always_ff @(posedge clk) begin
    if (v0) begin
      mem_addr[tail] <= bus.ld_waddr;
      mem_data[tail] <= bus.ld_wdata;
    end
    if (v1) begin
      mem_addr[slot1] <= bus.res1_waddr;
      mem_data[slot1] <= bus.res1_wdata;
    end
    if (v2) begin
      mem_addr[slot2] <= bus.res2_waddr;
      mem_data[slot2] <= bus.res2_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else begin
      head  <= head + {1'b0, deq_n};
      tail  <= tail + {1'b0, enq_n};
      count <= count + {2'b00, enq_n} - {2'b00, deq_n};
    end
  end

  // Port 2 always carries the younger entry so it wins on an address clash.
  assign head_p1      = head + 3'd1;
  assign bus.we_i1    = (count >= 4'd1);
  assign bus.waddr_i1 = bus.we_i1 ? mem_addr[head] : 5'd0;
  assign bus.wdata_i1 = bus.we_i1 ? mem_data[head] : 32'd0;
  assign bus.we_i2    = (count >= 4'd2);
  assign bus.waddr_i2 = bus.we_i2 ? mem_addr[head_p1] : 5'd0;
  assign bus.wdata_i2 = bus.we_i2 ? mem_data[head_p1] : 32'd0;

  assign bus.occupancy = count;

  assign chk_addr[0] = bus.chk_addr0;
  assign chk_addr[1] = bus.chk_addr1;
  assign chk_addr[2] = bus.chk_addr2;
  assign chk_addr[3] = bus.chk_addr3;

  always_comb begin
    entry_vld = '0;
    for (int i = 0; i < 8; i++) begin
      off[i]       = 3'(i) - head;
      entry_vld[i] = ({1'b0, off[i]} < count);
    end
  end

  always_comb begin
    chk_busy = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        if ((chk_addr[k] != 5'd0) && entry_vld[i] && (mem_addr[i] == chk_addr[k]))
          chk_busy[k] = 1'b1;
      end
    end
  end

  assign bus.chk_busy0 = chk_busy[0];
  assign bus.chk_busy1 = chk_busy[1];
  assign bus.chk_busy2 = chk_busy[2];
  assign bus.chk_busy3 = chk_busy[3];
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: hand-computed expectations per step.
module tb_regfile_wb_ctrl;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;
  logic [31:0] rf [32];
  logic [36:0] wq [$];

  regfile_wb_ctrl_if bus_if ();

  regfile_wb_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model and write log, fed from the write ports at each edge.
  always @(posedge clk) begin
    if (bus_if.we_i1) begin
      rf[bus_if.waddr_i1] = bus_if.wdata_i1;
      wq.push_back({bus_if.waddr_i1, bus_if.wdata_i1});
    end
    if (bus_if.we_i2) begin
      rf[bus_if.waddr_i2] = bus_if.wdata_i2;
      wq.push_back({bus_if.waddr_i2, bus_if.wdata_i2});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ldat,
                       input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                       input logic r2v, input logic [4:0] r2a, input logic [31:0] r2d);
    bus_if.ld_valid   = lv;  bus_if.ld_waddr   = la;  bus_if.ld_wdata   = ldat;
    bus_if.res1_valid = r1v; bus_if.res1_waddr = r1a; bus_if.res1_wdata = r1d;
    bus_if.res2_valid = r2v; bus_if.res2_waddr = r2a; bus_if.res2_wdata = r2d;
  endtask

  task automatic clr_in();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    clr_in();
    bus_if.chk_addr0 = 5'd0;
    bus_if.chk_addr1 = 5'd0;
    bus_if.chk_addr2 = 5'd0;
    bus_if.chk_addr3 = 5'd0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    // Reset state
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("rst_we_i1",    64'(bus_if.we_i1),    64'd0);
    chk("rst_we_i2",    64'(bus_if.we_i2),    64'd0);
    chk("rst_waddr_i1", 64'(bus_if.waddr_i1), 64'd0);
    chk("rst_occ",      64'(bus_if.occupancy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Single res1 from empty
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    tick();
    clr_in();
    chk("s1_we_i1",    64'(bus_if.we_i1),     64'd1);
    chk("s1_waddr_i1", 64'(bus_if.waddr_i1),  64'd5);
    chk("s1_wdata_i1", 64'(bus_if.wdata_i1),  64'h11);
    chk("s1_we_i2",    64'(bus_if.we_i2),     64'd0);
    chk("s1_waddr_i2", 64'(bus_if.waddr_i2),  64'd0);
    chk("s1_occ",      64'(bus_if.occupancy), 64'd1);
    tick();
    chk("s1_occ_after", 64'(bus_if.occupancy), 64'd0);
    chk("s1_we_after",  64'(bus_if.we_i1),     64'd0);

    // Three results, same destination on the older two
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b1, 5'd4, 32'hC);
    tick();
    clr_in();
    chk("s2_occ3",     64'(bus_if.occupancy), 64'd3);
    chk("s2_waddr_i1", 64'(bus_if.waddr_i1),  64'd3);
    chk("s2_wdata_i1", 64'(bus_if.wdata_i1),  64'hA);
    chk("s2_we_i2",    64'(bus_if.we_i2),     64'd1);
    chk("s2_waddr_i2", 64'(bus_if.waddr_i2),  64'd3);
    chk("s2_wdata_i2", 64'(bus_if.wdata_i2),  64'hB);
    tick();
    chk("s2_occ1",      64'(bus_if.occupancy), 64'd1);
    chk("s2_waddr_i1b", 64'(bus_if.waddr_i1),  64'd4);
    chk("s2_wdata_i1b", 64'(bus_if.wdata_i1),  64'hC);
    chk("s2_we_i2b",    64'(bus_if.we_i2),     64'd0);
    chk("s2_wdata_i2b", 64'(bus_if.wdata_i2),  64'd0);
    tick();
    chk("s2_occ0", 64'(bus_if.occupancy), 64'd0);
    chk("s2_rf3",  64'(rf[3]), 64'hB);
    chk("s2_rf4",  64'(rf[4]), 64'hC);

    // r0 destination dropped without leaving a gap
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd7, 32'h7);
    tick();
    clr_in();
    chk("s3_occ",      64'(bus_if.occupancy), 64'd1);
    chk("s3_waddr_i1", 64'(bus_if.waddr_i1),  64'd7);
    chk("s3_wdata_i1", 64'(bus_if.wdata_i1),  64'h7);
    chk("s3_we_i2",    64'(bus_if.we_i2),     64'd0);
    tick();
    chk("s3_occ0", 64'(bus_if.occupancy), 64'd0);

    // Full rate for 4 cycles: count 3,4,5,6 then stall
    wq.delete();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'(3*c+1), 32'h100 + 32'(3*c+1),
            1'b1, 5'(3*c+2), 32'h100 + 32'(3*c+2),
            1'b1, 5'(3*c+3), 32'h100 + 32'(3*c+3));
      tick();
      chk("s4_occ", 64'(bus_if.occupancy), 64'(c + 3));
      chk("s4_in_ready", 64'(bus_if.in_ready), (c < 3) ? 64'd1 : 64'd0);
    end
    // Result offered while stalled is dropped
    drive(1'b1, 5'd20, 32'h120, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    clr_in();
    chk("s4_stall_occ",   64'(bus_if.occupancy), 64'd4);
    chk("s4_ready_again", 64'(bus_if.in_ready),  64'd1);
    tick();
    chk("s4_occ2", 64'(bus_if.occupancy), 64'd2);
    tick();
    chk("s4_drained", 64'(bus_if.occupancy), 64'd0);
    chk("s4_nwrites", 64'(wq.size()), 64'd12);
    for (int k = 0; k < 12; k++)
      chk("s4_order", 64'(wq[k]), 64'({5'(k+1), 32'h100 + 32'(k+1)}));

    // Pending-write check ports
    bus_if.chk_addr0 = 5'd0;
    bus_if.chk_addr1 = 5'd5;
    bus_if.chk_addr2 = 5'd9;
    bus_if.chk_addr3 = 5'd11;
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB);
    #1;
    chk("s5_busy2_enq_excl", 64'(bus_if.chk_busy2), 64'd0);
    tick();
    clr_in();
    chk("s5_busy0", 64'(bus_if.chk_busy0), 64'd0);
    chk("s5_busy1", 64'(bus_if.chk_busy1), 64'd0);
    chk("s5_busy2", 64'(bus_if.chk_busy2), 64'd1);
    chk("s5_busy3", 64'(bus_if.chk_busy3), 64'd1);
    tick();
    chk("s5_busy2_drop", 64'(bus_if.chk_busy2), 64'd0);
    chk("s5_busy3_held", 64'(bus_if.chk_busy3), 64'd1);
    tick();
    chk("s5_busy3_drop", 64'(bus_if.chk_busy3), 64'd0);
    chk("s5_occ0",       64'(bus_if.occupancy), 64'd0);

    // Asynchronous reset with 5 entries pending
    bus_if.chk_addr2 = 5'd27;
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    tick();
    drive(1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25, 1'b1, 5'd26, 32'h26);
    tick();
    drive(1'b1, 5'd27, 32'h27, 1'b1, 5'd28, 32'h28, 1'b1, 5'd29, 32'h29);
    tick();
    clr_in();
    chk("s6_occ5",    64'(bus_if.occupancy), 64'd5);
    chk("s6_busy2",   64'(bus_if.chk_busy2), 64'd1);
    #2 resetn = 1'b0;
    wq.delete();
    #1;
    chk("s6_occ_rst",      64'(bus_if.occupancy), 64'd0);
    chk("s6_we_i1_rst",    64'(bus_if.we_i1),     64'd0);
    chk("s6_waddr_i1_rst", 64'(bus_if.waddr_i1),  64'd0);
    chk("s6_wdata_i1_rst", 64'(bus_if.wdata_i1),  64'd0);
    chk("s6_we_i2_rst",    64'(bus_if.we_i2),     64'd0);
    chk("s6_wdata_i2_rst", 64'(bus_if.wdata_i2),  64'd0);
    chk("s6_ready_rst",    64'(bus_if.in_ready),  64'd1);
    chk("s6_busy2_rst",    64'(bus_if.chk_busy2), 64'd0);
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    tick();
    chk("s6_no_writes",  64'(wq.size()),         64'd0);
    chk("s6_occ_after",  64'(bus_if.occupancy),  64'd0);
    chk("s6_ready_after", 64'(bus_if.in_ready),  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
